// File: rtl/ho_pkg.sv
// Shared types for the handover decision stage: BS identifiers, FSM states, default widths.
package ho_pkg;

    typedef logic [1:0] bs_id_t;

    localparam bs_id_t BS_NONE = 2'd0;
    localparam bs_id_t BS1     = 2'd1;
    localparam bs_id_t BS2     = 2'd2;
    localparam bs_id_t BS3     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SNAP    = 2'd1,
        EVAL    = 2'd2,
        RESPOND = 2'd3
    } ho_state_t;

    localparam int SQ_W_DEF = 8;

endpackage

// File: rtl/sq_iir_filter.sv
// Per-BS first-order IIR smoother: avg += (sample - avg) >>> ALPHA_SHIFT, clamped to the SQ_W range.
module sq_iir_filter #(
    parameter int              SQ_W        = 8,
    parameter int              ALPHA_SHIFT = 2,
    parameter logic [SQ_W-1:0] INIT_SQ     = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sq_valid,
    input  logic [SQ_W-1:0] sq_value,
    output logic [SQ_W-1:0] avg
);

    logic signed [SQ_W:0]   diff;
    logic signed [SQ_W+1:0] step;
    logic signed [SQ_W+1:0] sum;
    logic        [SQ_W-1:0] avg_nxt;

    always_comb begin
        diff = $signed({1'b0, sq_value}) - $signed({1'b0, avg});
        step = {diff[SQ_W], diff};
        step = step >>> ALPHA_SHIFT;
        sum  = $signed({2'b00, avg}) + step;
        // floor-shift keeps the result inside range today, clamp guards other parameterisations
        if (sum[SQ_W+1])   avg_nxt = '0;
        else if (sum[SQ_W]) avg_nxt = '1;
        else                avg_nxt = sum[SQ_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      avg <= INIT_SQ;
        else if (sq_valid) avg <= avg_nxt;
    end

endmodule

// File: rtl/dm_handover_selector.sv
// Handover decision stage: filters per-BS quality, answers the serving BS's request with a target ID.
// Optional time-to-trigger gating is enabled by defining HO_TTT_EN.
module dm_handover_selector
    import ho_pkg::*;
#(
    parameter int              SQ_W         = SQ_W_DEF,
    parameter int              ALPHA_SHIFT  = 2,
    parameter logic [SQ_W-1:0] INIT_SQ      = '0,
    parameter logic [SQ_W-1:0] HYST         = SQ_W'(10),
`ifdef HO_TTT_EN
    parameter int              TTT_COUNT    = 3,
`endif
    parameter bs_id_t          INIT_SERVING = BS1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sq_valid,
    input  bs_id_t          sq_bs_id,
    input  logic [SQ_W-1:0] sq_value,
    input  logic            req,
    input  bs_id_t          req_bs_id,
    output logic            target_valid,
    output bs_id_t          target_id,
    output bs_id_t          serving_id,
    output logic [SQ_W-1:0] serving_sq,
    output logic            busy
);

    function automatic logic [SQ_W-1:0] sel3(input bs_id_t id, input logic [3:1][SQ_W-1:0] a);
        case (id)
            BS1:     return a[1];
            BS2:     return a[2];
            BS3:     return a[3];
            default: return '0;
        endcase
    endfunction

    ho_state_t             state, state_nxt;
    logic [3:1][SQ_W-1:0]  avg, snap;
    logic                  req_q;
    bs_id_t                eval_k, best_id, nxt_best_id;
    logic [SQ_W-1:0]       best_avg, nxt_best_avg, cand, serv_avg;
    logic [SQ_W:0]         thr;
    logic                  take, pass, win, decide;

    for (genvar g = 1; g <= 3; g++) begin : g_bs
        sq_iir_filter #(
            .SQ_W        (SQ_W),
            .ALPHA_SHIFT (ALPHA_SHIFT),
            .INIT_SQ     (INIT_SQ)
        ) u_iir (
            .clk      (clk),
            .reset_n  (reset_n),
            .sq_valid (sq_valid && (sq_bs_id == bs_id_t'(g))),
            .sq_value (sq_value),
            .avg      (avg[g])
        );
    end

    // Running best over the snapshot; strict '>' in ascending ID order gives lower ID on ties.
    always_comb begin
        cand         = sel3(eval_k, snap);
        take         = (eval_k != serving_id) && ((best_id == BS_NONE) || (cand > best_avg));
        nxt_best_id  = take ? eval_k : best_id;
        nxt_best_avg = take ? cand   : best_avg;
        serv_avg     = sel3(serving_id, snap);
        thr          = {1'b0, serv_avg} + {1'b0, HYST};
        pass         = (nxt_best_id != BS_NONE) && ({1'b0, nxt_best_avg} >= thr);
        decide       = (state == EVAL) && (eval_k == BS3) && req && (req_bs_id == serving_id);
    end

`ifdef HO_TTT_EN
    localparam int CW = $clog2(TTT_COUNT + 1);
    logic [3:1][CW-1:0] ttt_cnt;
    logic               ttt_hit;

    always_comb begin
        ttt_hit = 1'b0;
        for (int i = 1; i <= 3; i++)
            if (nxt_best_id == bs_id_t'(i) && ttt_cnt[i] == CW'(TTT_COUNT - 1)) ttt_hit = 1'b1;
        win = pass && ttt_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ttt_cnt <= '0;
        end else if (decide) begin
            for (int i = 1; i <= 3; i++)
                ttt_cnt[i] <= (pass && nxt_best_id == bs_id_t'(i)) ? ttt_cnt[i] + 1'b1 : '0;
        end else if (state == RESPOND && !req && target_id != BS_NONE) begin
            ttt_cnt <= '0;
        end
    end
`else
    always_comb win = pass;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && !req_q) state_nxt = SNAP;
            SNAP:    state_nxt = EVAL;
            EVAL:    if (eval_k == BS3) state_nxt = RESPOND;
            RESPOND: if (!req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q        <= 1'b0;
            snap         <= '0;
            eval_k       <= BS1;
            best_id      <= BS_NONE;
            best_avg     <= '0;
            target_valid <= 1'b0;
            target_id    <= BS_NONE;
            serving_id   <= INIT_SERVING;
            serving_sq   <= INIT_SQ;
        end else begin
            req_q      <= req;
            serving_sq <= sel3(serving_id, avg);
            case (state)
                SNAP: begin
                    snap     <= avg;
                    eval_k   <= BS1;
                    best_id  <= BS_NONE;
                    best_avg <= '0;
                end
                EVAL: begin
                    eval_k   <= eval_k + 2'd1;
                    best_id  <= nxt_best_id;
                    best_avg <= nxt_best_avg;
                    // a request withdrawn during evaluation never sees target_valid rise
                    if (eval_k == BS3 && req) begin
                        target_valid <= 1'b1;
                        target_id    <= (decide && win) ? nxt_best_id : BS_NONE;
                    end
                end
                RESPOND: begin
                    if (!req) begin
                        target_valid <= 1'b0;
                        target_id    <= BS_NONE;
                        if (target_id != BS_NONE) serving_id <= target_id;
                    end
                end
                default: ;
            endcase
        end
    end

    a_serving_nonzero: assert property (@(posedge clk) disable iff (!reset_n) serving_id != BS_NONE);

endmodule

// File: tb/tb_dm_handover_selector.sv
// Directed bench for dm_handover_selector; TTT scenarios are exercised when HO_TTT_EN is defined.
module tb_dm_handover_selector;
    import ho_pkg::*;

`ifdef HO_TTT_EN
    localparam bit TTT = 1'b1;
`else
    localparam bit TTT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sq_valid = 1'b0;
    bs_id_t     sq_bs_id = BS_NONE;
    logic [7:0] sq_value = '0;
    logic       req = 1'b0;
    bs_id_t     req_bs_id = BS_NONE;
    logic       target_valid;
    bs_id_t     target_id;
    bs_id_t     serving_id;
    logic [7:0] serving_sq;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_handover_selector dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sq_valid     (sq_valid),
        .sq_bs_id     (sq_bs_id),
        .sq_value     (sq_value),
        .req          (req),
        .req_bs_id    (req_bs_id),
        .target_valid (target_valid),
        .target_id    (target_id),
        .serving_id   (serving_id),
        .serving_sq   (serving_sq),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; req = 1'b0; sq_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Overshoot high then settle from above: the floor shift walks down to exactly v.
    task automatic set_avg(input bs_id_t bs, input logic [7:0] v);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            sq_valid = 1'b1; sq_bs_id = bs;
            sq_value = (i < 20) ? 8'd255 : v;
        end
        @(negedge clk);
        sq_valid = 1'b0; sq_bs_id = BS_NONE;
    endtask

    task automatic set3(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
        set_avg(BS1, a1); set_avg(BS2, a2); set_avg(BS3, a3);
    endtask

    task automatic do_req(input string tag, input bs_id_t id, input bs_id_t exp_tid);
        logic early = 1'b0;
        @(negedge clk);
        req = 1'b1; req_bs_id = id;
        repeat (4) begin
            @(negedge clk);
            early |= target_valid;
        end
        chk({tag, "_early"}, early, 0);
        @(negedge clk);
        chk({tag, "_tv"}, target_valid, 1);
        chk({tag, "_tid"}, target_id, exp_tid);
        req = 1'b0;
        @(negedge clk);
        chk({tag, "_tv_drop"}, target_valid, 0);
        chk({tag, "_busy_drop"}, busy, 0);
    endtask

    int exp_f[8] = '{50, 87, 115, 136, 152, 164, 173, 179};

    initial begin
        logic seen;

        // reset state
        #12;
        chk("rst_tv", target_valid, 0);
        chk("rst_tid", target_id, 0);
        chk("rst_serv", serving_id, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sq", serving_sq, 0);
        do_reset();

        // filter step response
        @(negedge clk);
        sq_valid = 1'b1; sq_bs_id = BS2; sq_value = 8'd200;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("filt_%0d", i), dut.g_bs[2].u_iir.avg, exp_f[i]);
        end
        sq_valid = 1'b0; sq_bs_id = BS_NONE;

        // basic handover
        do_reset();
        set3(8'd40, 8'd60, 8'd55);
        chk("ho_sq_before", serving_sq, 40);
        do_req("ho", BS1, TTT ? BS_NONE : BS2);
        chk("ho_serv", serving_id, TTT ? 1 : 2);
        @(negedge clk);
        chk("ho_sq_after", serving_sq, TTT ? 40 : 60);

        // hysteresis miss then tie resolved to lower ID
        do_reset();
        set3(8'd50, 8'd59, 8'd59);
        do_req("hyst", BS1, BS_NONE);
        chk("hyst_serv", serving_id, 1);
        set_avg(BS2, 8'd70); set_avg(BS3, 8'd70);
        do_req("tie", BS1, TTT ? BS_NONE : BS2);
        chk("tie_serv", serving_id, TTT ? 1 : 2);

        // request from a non-serving BS is rejected
        do_reset();
        set_avg(BS3, 8'd100);
        do_req("rej", BS3, BS_NONE);
        chk("rej_serv", serving_id, 1);

        // request withdrawn before the response
        do_reset();
        set3(8'd40, 8'd60, 8'd55);
        @(negedge clk);
        req = 1'b1; req_bs_id = BS1;
        repeat (2) @(negedge clk);
        req = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= target_valid;
        end
        chk("drop_tv", seen, 0);
        chk("drop_serv", serving_id, 1);
        chk("drop_busy", busy, 0);

        // asynchronous reset in the middle of RESPOND
        @(negedge clk);
        req = 1'b1; req_bs_id = BS1;
        repeat (5) @(negedge clk);
        chk("arst_pre_tv", target_valid, 1);
        chk("arst_pre_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_tv", target_valid, 0);
        chk("arst_tid", target_id, 0);
        chk("arst_serv", serving_id, 1);
        chk("arst_busy", busy, 0);
        chk("arst_avg2", dut.g_bs[2].u_iir.avg, 0);
        chk("arst_sq", serving_sq, 0);
        req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

`ifdef HO_TTT_EN
        // three consecutive wins hand over on the third request
        do_reset();
        set3(8'd40, 8'd60, 8'd80);
        do_req("ttt_a1", BS1, BS_NONE);
        do_req("ttt_a2", BS1, BS_NONE);
        do_req("ttt_a3", BS1, BS3);
        chk("ttt_a_serv", serving_id, 3);

        // a different winner in between restarts the count
        do_reset();
        set3(8'd40, 8'd60, 8'd80);
        do_req("ttt_b1", BS1, BS_NONE);
        do_req("ttt_b2", BS1, BS_NONE);
        set_avg(BS2, 8'd100);
        do_req("ttt_b3", BS1, BS_NONE);
        set_avg(BS2, 8'd60);
        do_req("ttt_b4", BS1, BS_NONE);
        chk("ttt_b_serv", serving_id, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
